// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter
//   Packet-level round-robin arbiter that shares one AXI-Stream output
//   between N_IN input streams. A grant is held from the first beat of a
//   packet until its tlast beat transfers, so packets never interleave.
//   After each packet the priority pointer moves to the input just past
//   the winner.
//
// Parameters
//   N_IN    number of requesting input streams
//   DATA_W  tdata width
//   IDX_W   source index width, derived from N_IN (leave at default)
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_tdata/tvalid/
//   in_tlast/in_tready  per-input streams, slice i = [i*DATA_W +: DATA_W]
//   out_tdata/tvalid/
//   out_tlast/out_tid/
//   out_tready          merged output stream, out_tid = source index
//   grant_valid         high while a packet grant is held
//   grant_idx           granted input, 0 when no grant is held
//
// Build option
//   ARB_OUT_SKID_EN     when defined, a 2-entry skid buffer registers all
//                       out_* signals and cuts the out_tready -> in_tready
//                       path; adds one cycle of latency.

module axis_packet_arbiter #(
  parameter int N_IN   = 5,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_IN*DATA_W-1:0] in_tdata,
  input  logic [N_IN-1:0]        in_tvalid,
  input  logic [N_IN-1:0]        in_tlast,
  output logic [N_IN-1:0]        in_tready,
  output logic [DATA_W-1:0]      out_tdata,
  output logic                   out_tvalid,
  output logic                   out_tlast,
  output logic [IDX_W-1:0]       out_tid,
  input  logic                   out_tready,
  output logic                   grant_valid,
  output logic [IDX_W-1:0]       grant_idx
);

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gnt;

  logic               req_found;
  logic [IDX_W-1:0]   req_idx;
  logic [IDX_W-1:0]   cand;

  logic [DATA_W-1:0]  sel_data;
  logic               sel_valid;
  logic               sel_last;

  logic               active;
  logic               tail_xfer;

  // Round-robin search starting at ptr and wrapping at N_IN-1.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    cand      = ptr;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (!req_found && in_tvalid[cand]) begin
        req_found = 1'b1;
        req_idx   = cand;
      end
      cand = (cand == IDX_W'(N_IN - 1)) ? '0 : cand + IDX_W'(1);
    end
  end

  // Mux of the granted input's stream signals.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (gnt == IDX_W'(i)) begin
        sel_data  = in_tdata[i*DATA_W +: DATA_W];
        sel_valid = in_tvalid[i];
        sel_last  = in_tlast[i];
      end
    end
  end

  // Gated by rst_n so every output reads idle while reset is asserted.
  assign active      = rst_n && (state == S_LOCKED);
  assign grant_valid = active;
  assign grant_idx   = active ? gnt : '0;

`ifdef ARB_OUT_SKID_EN

  logic [DATA_W-1:0] sk_data [2];
  logic              sk_last [2];
  logic [IDX_W-1:0]  sk_tid  [2];
  logic              sk_wr_p;
  logic              sk_rd_p;
  logic [1:0]        sk_cnt;
  logic [1:0]        sk_cnt_next;
  logic              sk_room;
  logic              sk_push;
  logic              sk_pop;

  // Input side handshakes against the registered room flag only.
  assign sk_push   = (state == S_LOCKED) && sel_valid && sk_room;
  assign sk_pop    = (sk_cnt != 2'd0) && out_tready;
  assign tail_xfer = sk_push && sel_last;

  always_comb begin
    sk_cnt_next = sk_cnt;
    if (sk_push && !sk_pop) begin
      sk_cnt_next = sk_cnt + 2'd1;
    end else if (!sk_push && sk_pop) begin
      sk_cnt_next = sk_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sk_cnt  <= 2'd0;
      sk_wr_p <= 1'b0;
      sk_rd_p <= 1'b0;
      sk_room <= 1'b1;
    end else begin
      sk_cnt  <= sk_cnt_next;
      sk_room <= (sk_cnt_next < 2'd2);
      if (sk_push) sk_wr_p <= ~sk_wr_p;
      if (sk_pop)  sk_rd_p <= ~sk_rd_p;
    end
  end

  always_ff @(posedge clk) begin
    if (sk_push) begin
      sk_data[sk_wr_p] <= sel_data;
      sk_last[sk_wr_p] <= sel_last;
      sk_tid[sk_wr_p]  <= gnt;
    end
  end

  always_comb begin
    in_tready = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (active && gnt == IDX_W'(i)) in_tready[i] = sk_room;
    end
  end

  assign out_tvalid = rst_n && (sk_cnt != 2'd0);
  assign out_tdata  = out_tvalid ? sk_data[sk_rd_p] : '0;
  assign out_tlast  = out_tvalid && sk_last[sk_rd_p];
  assign out_tid    = out_tvalid ? sk_tid[sk_rd_p] : '0;

`else

  assign tail_xfer = (state == S_LOCKED) && sel_valid && sel_last && out_tready;

  always_comb begin
    in_tready = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (active && gnt == IDX_W'(i)) in_tready[i] = out_tready;
    end
  end

  assign out_tvalid = active && sel_valid;
  assign out_tlast  = active && sel_last;
  assign out_tdata  = active ? sel_data : '0;
  assign out_tid    = active ? gnt : '0;

`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ptr   <= '0;
      gnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_found) begin
            state <= S_LOCKED;
            gnt   <= req_idx;
          end
        end
        S_LOCKED: begin
          if (tail_xfer) begin
            state <= S_IDLE;
            ptr   <= (gnt == IDX_W'(N_IN - 1)) ? '0 : gnt + IDX_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
